// File: rtl/t06_frame_scan_ctrl.sv
// t06_frame_scan_ctrl: steps the frame tracker through every cell once per
// game tick. Cells flagged as changed are queued in a small FWFT FIFO for the
// LCD draw engine. The scan stalls while that FIFO is full.
// Optional build macro T06_SCAN_CHECK_EN: checks the tracker position against
// an expected raster counter, flags scan_err, and resyncs the tracker.
module t06_frame_scan_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int NUM_CELLS  = 192
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_start,
    input  logic [3:0] trk_x,
    input  logic [3:0] trk_y,
    input  logic       trk_diff,
    input  logic [2:0] trk_obj_code,
    output logic       trk_enable,
    output logic       trk_sync,
    output logic       draw_valid,
    output logic [3:0] draw_x,
    output logic [3:0] draw_y,
    output logic [2:0] draw_obj,
    input  logic       draw_ready,
    output logic       busy,
    output logic       frame_done,
    output logic [7:0] diff_count,
    output logic       overrun,
    output logic       scan_err
);

    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = AW + 1;
    localparam int CELL_W = $clog2(NUM_CELLS + 1);
    localparam logic [CELL_W-1:0] LAST_CELL = CELL_W'(NUM_CELLS - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_SCAN,
        S_DRAIN,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [3:0] x;
        logic [3:0] y;
        logic [2:0] obj;
    } draw_ent_t;

    state_t              state;
    logic [CELL_W-1:0]   cell_cnt;
    draw_ent_t           fifo_mem [FIFO_DEPTH];
    draw_ent_t           head;
    logic [AW-1:0]       rd_ptr;
    logic [AW-1:0]       wr_ptr;
    logic [CNT_W-1:0]    fifo_cnt;
    logic [CNT_W-1:0]    cnt_nxt;
    logic                fifo_full;
    logic                fifo_empty;
    logic                push;
    logic                pop;
    logic                resync_req;

    // Enable is gated by the registered fill level, so a pop in a full
    // cycle only frees a slot for the following cycle.
    assign fifo_full  = (fifo_cnt == FULL_CNT);
    assign fifo_empty = (fifo_cnt == '0);
    assign trk_enable = (state == S_SCAN) && !fifo_full;
    assign push       = trk_enable && trk_diff;
    assign pop        = draw_valid && draw_ready;

    // FWFT head; data lines read zero while nothing is queued
    assign head       = fifo_mem[rd_ptr];
    assign draw_valid = !fifo_empty;
    assign draw_x     = fifo_empty ? 4'd0 : head.x;
    assign draw_y     = fifo_empty ? 4'd0 : head.y;
    assign draw_obj   = fifo_empty ? 3'd0 : head.obj;

    // Next fill level; simultaneous push and pop leave it unchanged
    always_comb begin
        cnt_nxt = fifo_cnt;
        if (push && !pop)
            cnt_nxt = fifo_cnt + 1'b1;
        else if (pop && !push)
            cnt_nxt = fifo_cnt - 1'b1;
    end

    // FIFO storage, written only on push (contents need no reset)
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= '{x: trk_x, y: trk_y, obj: trk_obj_code};
    end

    // FIFO pointers and fill level; reset discards queued entries
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            fifo_cnt <= cnt_nxt;
        end
    end

`ifdef T06_SCAN_CHECK_EN
    logic [3:0] ex;
    logic [3:0] ey;
    logic       resync_pend;

    // Expected raster position (X fastest); a mismatch latches scan_err and
    // requests one tracker resync on the way back to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex          <= 4'd0;
            ey          <= 4'd0;
            scan_err    <= 1'b0;
            resync_pend <= 1'b0;
        end else if (state == S_INIT) begin
            ex          <= 4'd0;
            ey          <= 4'd0;
            resync_pend <= 1'b0;
        end else if (trk_enable) begin
            if (ex == 4'd15) begin
                ex <= 4'd0;
                ey <= (ey == 4'd11) ? 4'd0 : ey + 4'd1;
            end else begin
                ex <= ex + 4'd1;
            end
            if (trk_x != ex || trk_y != ey) begin
                scan_err    <= 1'b1;
                resync_pend <= 1'b1;
            end
        end
    end

    assign resync_req = resync_pend;
`else
    assign scan_err   = 1'b0;
    assign resync_req = 1'b0;
`endif

    // Scan sequencer with registered status outputs. INIT spends one cycle
    // with outputs quiet and one cycle issuing the sync, so reset itself
    // never shows a sync pulse or busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_INIT;
            cell_cnt   <= '0;
            diff_count <= 8'd0;
            trk_sync   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            trk_sync   <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= frame_start && (state != S_IDLE);
            case (state)
                S_INIT: begin
                    if (!trk_sync) begin
                        trk_sync <= 1'b1;
                        busy     <= 1'b1;
                    end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                S_IDLE: begin
                    if (frame_start) begin
                        state      <= S_SCAN;
                        busy       <= 1'b1;
                        cell_cnt   <= '0;
                        diff_count <= 8'd0;
                    end
                end
                S_SCAN: begin
                    if (trk_enable) begin
                        cell_cnt <= cell_cnt + 1'b1;
                        if (trk_diff && diff_count != 8'hFF)
                            diff_count <= diff_count + 8'd1;
                        if (cell_cnt == LAST_CELL)
                            state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (cnt_nxt == '0) begin
                        state      <= S_DONE;
                        frame_done <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (resync_req) begin
                        state <= S_INIT;
                    end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= S_INIT;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_t06_frame_scan_ctrl.sv
// Directed bench for t06_frame_scan_ctrl: a behavioural tracker supplies the
// cell stream, a negedge monitor records enables/pops/pulses, and a single
// check task compares against hand-computed values.
module tb_t06_frame_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_start = 1'b0;
    logic [3:0] trk_x;
    logic [3:0] trk_y;
    logic       trk_diff;
    logic [2:0] trk_obj_code;
    logic       trk_enable;
    logic       trk_sync;
    logic       draw_valid;
    logic [3:0] draw_x;
    logic [3:0] draw_y;
    logic [2:0] draw_obj;
    logic       draw_ready = 1'b0;
    logic       busy;
    logic       frame_done;
    logic [7:0] diff_count;
    logic       overrun;
    logic       scan_err;

    t06_frame_scan_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .frame_start  (frame_start),
        .trk_x        (trk_x),
        .trk_y        (trk_y),
        .trk_diff     (trk_diff),
        .trk_obj_code (trk_obj_code),
        .trk_enable   (trk_enable),
        .trk_sync     (trk_sync),
        .draw_valid   (draw_valid),
        .draw_x       (draw_x),
        .draw_y       (draw_y),
        .draw_obj     (draw_obj),
        .draw_ready   (draw_ready),
        .busy         (busy),
        .frame_done   (frame_done),
        .diff_count   (diff_count),
        .overrun      (overrun),
        .scan_err     (scan_err)
    );

    always #5 clk = ~clk;

    // tracker model: raster position, cleared by sync, advanced by enable
    logic [7:0] pos = 8'd0;
    logic [191:0] diff_map = '0;
    logic [2:0]   obj_map [192];
    logic         force_en = 1'b0;
    logic [7:0]   force_cell = 8'd0;

    always @(posedge clk) begin
        if (trk_sync)
            pos <= 8'd0;
        else if (trk_enable)
            pos <= (pos == 8'd191) ? 8'd0 : pos + 8'd1;
    end

    assign trk_x        = (force_en && pos == force_cell) ? 4'd7 : pos[3:0];
    assign trk_y        = pos[7:4];
    assign trk_diff     = diff_map[pos];
    assign trk_obj_code = obj_map[pos];

    // cycle counter and negedge monitor
    int cyc = 0;
    int en_cnt, first_en, last_en, done_cnt, done_cyc, ovr_cnt, vld_cnt;
    int sync_cnt = 0;
    logic [10:0] pop_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (trk_enable) begin
            if (first_en < 0) first_en = cyc;
            last_en = cyc;
            en_cnt++;
        end
        if (frame_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (overrun) ovr_cnt++;
        if (trk_sync) sync_cnt++;
        if (draw_valid) begin
            vld_cnt++;
            if (draw_ready) pop_q.push_back({draw_x, draw_y, draw_obj});
        end
    end

    int n_chk = 0;
    int n_err = 0;
    int start_cyc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ent(input int x, input int y, input int o);
        return (x << 7) | (y << 3) | o;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_map();
        diff_map = '0;
        for (int i = 0; i < 192; i++) obj_map[i] = 3'd0;
    endtask

    task automatic set_cell(input int x, input int y, input int o);
        diff_map[y * 16 + x] = 1'b1;
        obj_map[y * 16 + x]  = 3'(o);
    endtask

    task automatic start_frame();
        en_cnt = 0; first_en = -1; last_en = -1;
        done_cnt = 0; done_cyc = -1; ovr_cnt = 0; vld_cnt = 0;
        frame_start = 1'b1;
        start_cyc = cyc;
        step();
        frame_start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            step();
            if (done_cnt != 0) break;
        end
        check("done_seen", 32'(done_cnt != 0), 1);
        repeat (4) step();
    endtask

    initial begin
        clr_map();

        // reset: every output quiet while rst is held
        repeat (3) step();
        check("rst_outs", {trk_enable, trk_sync, draw_valid, draw_x, draw_y, draw_obj,
                           busy, frame_done, diff_count, overrun, scan_err}, 0);
        rst = 1'b0;
        step();
        check("init_sync", trk_sync, 1);
        check("init_busy", busy, 1);
        check("init_other", {trk_enable, draw_valid, frame_done, diff_count, overrun}, 0);
        step();
        check("idle_sync", trk_sync, 0);
        check("idle_busy", busy, 0);
        repeat (2) step();
        check("sync_once", sync_cnt, 1);

        // empty frame: 192 back-to-back enables, done at start+194
        draw_ready = 1'b1;
        pop_q.delete();
        start_frame();
        wait_done(400);
        check("t2_first_en", first_en, start_cyc + 1);
        check("t2_last_en", last_en, start_cyc + 192);
        check("t2_en_cnt", en_cnt, 192);
        check("t2_done_cyc", done_cyc, start_cyc + 194);
        check("t2_no_valid", vld_cnt, 0);
        check("t2_diff_cnt", diff_count, 0);
        check("t2_busy", busy, 0);

        // two changed cells, drawn in scan order
        clr_map();
        set_cell(3, 2, 3);
        set_cell(15, 11, 4);
        pop_q.delete();
        start_frame();
        wait_done(400);
        check("t3_pops", pop_q.size(), 2);
        if (pop_q.size() == 2) begin
            check("t3_pop0", pop_q[0], ent(3, 2, 3));
            check("t3_pop1", pop_q[1], ent(15, 11, 4));
        end
        check("t3_diff_cnt", diff_count, 2);
        check("t3_done_cnt", done_cnt, 1);
        check("t3_done_cyc", done_cyc, start_cyc + 194);
        check("t3_empty_data", {draw_valid, draw_x, draw_y, draw_obj}, 0);
        check("t3_diff_hold", diff_count, 2);

        // backpressure: FIFO fills after four pushes, fifth cell waits
        clr_map();
        for (int i = 0; i < 5; i++) set_cell(i, 0, i + 1);
        draw_ready = 1'b0;
        pop_q.delete();
        start_frame();
        repeat (12) step();
        check("t4_stall_en", en_cnt, 4);
        check("t4_enable_lo", trk_enable, 0);
        check("t4_valid", draw_valid, 1);
        check("t4_head", {draw_x, draw_y, draw_obj}, ent(0, 0, 1));
        check("t4_diff_mid", diff_count, 4);
        repeat (5) step();
        check("t4_head_hold", {draw_x, draw_y, draw_obj}, ent(0, 0, 1));
        check("t4_still_stall", en_cnt, 4);
        draw_ready = 1'b1;
        wait_done(400);
        check("t4_en_cnt", en_cnt, 192);
        check("t4_pops", pop_q.size(), 5);
        if (pop_q.size() == 5) begin
            check("t4_pop0", pop_q[0], ent(0, 0, 1));
            check("t4_pop4", pop_q[4], ent(4, 0, 5));
        end
        check("t4_diff_cnt", diff_count, 5);

        // frame_start while scanning: overrun pulse, scan not restarted
        clr_map();
        pop_q.delete();
        start_frame();
        repeat (20) step();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        check("t5_ovr_pulse", overrun, 1);
        step();
        check("t5_ovr_clear", overrun, 0);
        wait_done(400);
        check("t5_done_cyc", done_cyc, start_cyc + 194);
        check("t5_en_cnt", en_cnt, 192);
        check("t5_ovr_cnt", ovr_cnt, 1);
        check("t5_done_cnt", done_cnt, 1);

        // reset mid-scan with entries queued
        clr_map();
        for (int i = 0; i < 3; i++) set_cell(i, 0, 2);
        draw_ready = 1'b0;
        start_frame();
        for (int i = 0; i < 300; i++) begin
            if (en_cnt >= 100) break;
            step();
        end
        check("t6_reach_100", en_cnt, 100);
        rst = 1'b1;
        step();
        check("t6_rst_outs", {trk_enable, trk_sync, draw_valid, busy, diff_count}, 0);
        rst = 1'b0;
        step();
        check("t6_resync", trk_sync, 1);
        step();
        check("t6_sync_off", trk_sync, 0);
        check("t6_trk_home", pos, 0);
        clr_map();
        pop_q.delete();
        draw_ready = 1'b1;
        repeat (2) step();
        start_frame();
        wait_done(400);
        check("t6_flushed", pop_q.size(), 0);
        check("t6_en_cnt", en_cnt, 192);
        check("t6_done_cyc", done_cyc, start_cyc + 194);

`ifdef T06_SCAN_CHECK_EN
        // position mismatch at cell 5: sticky error plus one resync
        begin
            int s0;
            s0 = sync_cnt;
            force_cell = 8'd5;
            force_en = 1'b1;
            start_frame();
            wait_done(400);
            force_en = 1'b0;
            check("t7_scan_err", scan_err, 1);
            check("t7_resync", sync_cnt - s0, 1);
            check("t7_busy", busy, 0);
            s0 = sync_cnt;
            start_frame();
            wait_done(400);
            check("t7_sticky", scan_err, 1);
            check("t7_no_resync", sync_cnt - s0, 0);
        end
`else
        check("t7_scan_err_off", scan_err, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
